// File: rtl/ram_rd_stream_requester.sv
// Read-side initiator for a 1r1w sync RAM: turns {addr, len} commands into
// credit-limited read requests and streams the buffered responses out with a last marker.
module ram_rd_stream_requester #(
    parameter int WIDTH_P    = 64,
    parameter int ELS_P      = 256,
    parameter int ADDR_W_P   = (ELS_P > 1) ? $clog2(ELS_P) : 1,
    parameter int LEN_W_P    = 16,
    parameter int FIFO_ELS_P = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_val,
    input  logic [ADDR_W_P-1:0] cmd_addr,
    input  logic [LEN_W_P-1:0]  cmd_len,
    output logic                cmd_rdy,
    output logic                rd_req_val,
    output logic [ADDR_W_P-1:0] rd_req_addr,
    input  logic                rd_req_rdy,
    input  logic                rd_resp_val,
    input  logic [WIDTH_P-1:0]  rd_resp_data,
    output logic                rd_resp_rdy,
    output logic                out_val,
    output logic [WIDTH_P-1:0]  out_data,
    output logic                out_last,
    input  logic                out_rdy
);

    localparam int CNT_W = $clog2(FIFO_ELS_P + 1);
    localparam int PTR_W = $clog2(FIFO_ELS_P);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W_P-1:0]  addr_q, addr_d;
    logic [LEN_W_P-1:0]   len_q, len_d;
    logic [LEN_W_P-1:0]   rem_q, rem_d;
    logic [LEN_W_P-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]     credit_q, credit_d;
    logic [CNT_W-1:0]     fcnt_q, fcnt_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [WIDTH_P-1:0]   mem_q [FIFO_ELS_P];

    logic cmd_hs, req_hs, out_hs, push;

    assign cmd_hs = cmd_val & cmd_rdy;
    assign req_hs = rd_req_val & rd_req_rdy;
    assign out_hs = out_val & out_rdy;
    assign push   = rd_resp_val & (fcnt_q != CNT_W'(FIFO_ELS_P));

    assign cmd_rdy     = (state_q == IDLE);
    assign rd_req_val  = (state_q == ISSUE) & (credit_q < CNT_W'(FIFO_ELS_P));
    assign rd_req_addr = addr_q;
    assign rd_resp_rdy = 1'b1;
    assign out_val     = (fcnt_q != '0);
    assign out_data    = out_val ? mem_q[rd_ptr_q] : '0;
    assign out_last    = out_val & (out_cnt_q == len_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        out_cnt_d = out_cnt_q;
        if (out_hs) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d    = cmd_addr;
                    len_d     = cmd_len;
                    rem_d     = cmd_len;
                    out_cnt_d = '0;
                    state_d   = (cmd_len != '0) ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                if (req_hs) begin
                    addr_d = (addr_q == ADDR_W_P'(ELS_P - 1)) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W_P'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // credits cover both in-flight reads and buffered entries
    always_comb begin
        credit_d = credit_q;
        fcnt_d   = fcnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        unique case ({req_hs, out_hs})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
        unique case ({push, out_hs})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_ELS_P - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (out_hs) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_ELS_P - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            out_cnt_q <= '0;
            credit_q  <= '0;
            fcnt_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            out_cnt_q <= out_cnt_d;
            credit_q  <= credit_d;
            fcnt_q    <= fcnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rd_resp_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(rd_resp_val && fcnt_q == CNT_W'(FIFO_ELS_P)));

endmodule

// File: tb/tb_ram_rd_stream_requester.sv
// Randomised scoreboard bench for ram_rd_stream_requester with a 1-cycle RAM model.
module tb_ram_rd_stream_requester;

    localparam int W  = 64;
    localparam int E  = 256;
    localparam int AW = 8;
    localparam int LW = 8;
    localparam int F  = 4;

    logic          clk, rst;
    logic          cmd_val, cmd_rdy;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          rd_req_val, rd_req_rdy;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_val, rd_resp_rdy;
    logic [W-1:0]  rd_resp_data;
    logic          out_val, out_last, out_rdy;
    logic [W-1:0]  out_data;

    ram_rd_stream_requester #(
        .WIDTH_P(W), .ELS_P(E), .ADDR_W_P(AW), .LEN_W_P(LW), .FIFO_ELS_P(F)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
        .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr), .rd_req_rdy(rd_req_rdy),
        .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data), .rd_resp_rdy(rd_resp_rdy),
        .out_val(out_val), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] mem [E];
    initial for (int i = 0; i < E; i++) mem[i] = W'(i);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_resp_val  <= 1'b0;
            rd_resp_data <= '0;
        end else begin
            rd_resp_val  <= rd_req_val && rd_req_rdy;
            rd_resp_data <= mem[rd_req_addr];
        end
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   req_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_req = 0;
    int   n_out = 0;
    bit   rnd = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic          pv_req, pv_out;
    logic [AW-1:0] p_addr;
    logic [W-1:0]  p_data;
    exp_t          e;

    always @(negedge clk) begin
        if (rst) begin
            pv_req = 1'b0;
            pv_out = 1'b0;
        end else begin
            if (pv_req) begin
                chk("req_hold_val", 64'(rd_req_val), 64'd1);
                chk("req_hold_addr", 64'(rd_req_addr), 64'(p_addr));
            end
            if (pv_out) begin
                chk("out_hold_val", 64'(out_val), 64'd1);
                chk("out_hold_data", out_data, p_data);
            end
            if (out_val && out_rdy) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", 64'(out_last), 64'(e.last));
                end
            end
            if (rd_req_val && rd_req_rdy) begin
                n_req++;
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("req_addr", 64'(rd_req_addr), 64'(req_q.pop_front()));
                end
                chk("credit_bound", 64'(n_req - n_out <= F), 64'd1);
            end
            pv_req = rd_req_val && !rd_req_rdy;
            p_addr = rd_req_addr;
            pv_out = out_val && !out_rdy;
            p_data = out_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) begin
                out_rdy    = ($urandom_range(0, 3) != 0);
                rd_req_rdy = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic send_cmd(int a, int l);
        int t;
        exp_t x;
        t = 0;
        while (!cmd_rdy && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_accept_timeout", 64'(t < 3000), 64'd1);
        cmd_val  = 1'b1;
        cmd_addr = AW'(a);
        cmd_len  = LW'(l);
        for (int k = 0; k < l; k++) begin
            req_q.push_back((a + k) % E);
            x.data = mem[(a + k) % E];
            x.last = (k == l - 1);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && req_q.size() == 0 && cmd_rdy) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, 64'(t < 3000), 64'd1);
    endtask

    initial begin
        int n0, t;
        rst = 1'b1;
        cmd_val = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        out_rdy = 1'b1;
        rd_req_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_req_val", 64'(rd_req_val), 64'd0);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_req_addr", 64'(rd_req_addr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_resp_rdy", 64'(rd_resp_rdy), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // latency: out at N+3..N+5, cmd_rdy back at N+6
        send_cmd(5, 3);
        @(posedge clk); #1;
        chk("lat_out_early", 64'(out_val), 64'd0);
        @(posedge clk); #1;
        chk("lat_out_val", 64'(out_val), 64'd1);
        chk("lat_out_first", out_data, 64'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("lat_last", 64'(out_last), 64'd1);
        chk("lat_busy", 64'(cmd_rdy), 64'd0);
        @(posedge clk); #1;
        chk("lat_cmd_rdy", 64'(cmd_rdy), 64'd1);
        wait_idle("t1_done");

        send_cmd(254, 4);
        wait_idle("t2_wrap_done");

        out_rdy = 1'b0;
        n0 = n_req;
        send_cmd(0, 10);
        repeat (12) @(posedge clk);
        #1;
        chk("stall_reqs", 64'(n_req - n0), 64'd4);
        out_rdy = 1'b1;
        wait_idle("t3_done");

        rd_req_rdy = 1'b1;
        send_cmd(0, 6);
        t = 0;
        while (!(exp_q.size() == 0 && cmd_rdy) && t < 200) begin
            @(posedge clk);
            #1;
            rd_req_rdy = !rd_req_rdy;
            t++;
        end
        rd_req_rdy = 1'b1;
        chk("t4_done", 64'(t < 200), 64'd1);

        send_cmd(7, 0);
        chk("len0_cmd_rdy", 64'(cmd_rdy), 64'd1);
        repeat (5) begin
            chk("len0_req_val", 64'(rd_req_val), 64'd0);
            chk("len0_out_val", 64'(out_val), 64'd0);
            @(posedge clk);
            #1;
        end

        send_cmd(0, 8);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_val", 64'(out_val), 64'd0);
        chk("abort_req_val", 64'(rd_req_val), 64'd0);
        chk("abort_cmd_rdy", 64'(cmd_rdy), 64'd1);
        exp_q.delete();
        req_q.delete();
        n_req = 0;
        n_out = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_cmd(20, 2);
        wait_idle("t6_done");

        send_cmd(3, 255);
        wait_idle("maxlen_done");

        rnd = 1;
        repeat (40) begin
            send_cmd($urandom_range(0, E - 1),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20));
        end
        wait_idle("rand_done");
        rnd = 0;
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        rd_req_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("final_out_val", 64'(out_val), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
